// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// State encoding, double-dabble adjust constants and counter sizing.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_TH = 4'd5;
  localparam logic [3:0] BCD_ADJ    = 4'd3;

  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5,
// then shift the whole BCD vector left, inserting msb at bit 0.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                msb,
  output logic [4*DIGITS-1:0] bcd_nxt
);

  logic [4*DIGITS-1:0] adj;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [3:0] d;
    assign d = bcd[4*k +: 4];
    assign adj[4*k +: 4] = (d >= BCD_ADJ_TH) ? d + BCD_ADJ : d;
  end

  assign bcd_nxt = {adj[4*DIGITS-2:0], msb};

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter, one double-dabble step per clock,
// with valid/ready handshakes on both sides and one conversion in flight.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                busy
);

  localparam int             CW       = cnt_w(BIN_W);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(BIN_W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);

  if ((64'd10 ** DIGITS) < (64'd1 << BIN_W)) begin : g_bad_params
    $error("bcd_seq_converter: DIGITS too small for BIN_W");
  end

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [BIN_W-1:0]    bin_sr;
  logic [4*DIGITS-1:0] bcd_sr;
  logic [4*DIGITS-1:0] step_bcd;
  logic                accept;
  logic                last;

  assign accept = in_valid && in_ready && (state == IDLE);
  assign last   = (cnt == CNT_LAST);

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .bcd     (bcd_sr),
    .msb     (bin_sr[BIN_W-1]),
    .bcd_nxt (step_bcd)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they
  // stay low through reset and rise only after the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
    end else if (accept) begin
      cnt    <= CNT_LOAD;
      bin_sr <= bin_in;
      bcd_sr <= '0;
    end else if (state == SHIFT) begin
      cnt    <= cnt - CNT_LAST;
      bin_sr <= bin_sr << 1;
      bcd_sr <= step_bcd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out <= '0;
    end else if (state == SHIFT && last) begin
      bcd_out <= step_bcd;
    end
  end

endmodule
